// File: rtl/timeout_gen.sv
// ---------------------------------------------------------------------------
// timeout_gen
// Countdown timer with 100 ms and one-second strobes.
//
// A prescaler divides clk down to a 100 ms tick.
// A tenths counter divides that down to a one-second tick.
// Each one-second tick decrements SecsLeft. The block expires when SecsLeft
// reaches zero.
//
// Ports
//   clk              in   single clock, rising edge
//   rst              in   asynchronous active-high reset
//   Load             in   load LoadSecs, clear counters, go IDLE (highest priority)
//   LoadSecs[7:0]    in   countdown start value in seconds
//   Start            in   start from IDLE / resume from PAUSED
//   Pause            in   freeze the countdown (wins over Start)
//   HundredmsTimeout out  one-cycle strobe every 100 ms of run time
//   OnesecTimeout    out  one-cycle strobe every TICKS_PER_SEC 100 ms strobes
//   SecsLeft[7:0]    out  seconds remaining
//   Running          out  high in RUN
//   Expired          out  high in EXPIRED
// ---------------------------------------------------------------------------
module timeout_gen #(
   parameter int CYCLES_PER_100MS = 5000000,
   parameter int TICKS_PER_SEC    = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Load,
   input  logic [7:0] LoadSecs,
   input  logic       Start,
   input  logic       Pause,
   output logic       HundredmsTimeout,
   output logic       OnesecTimeout,
   output logic [7:0] SecsLeft,
   output logic       Running,
   output logic       Expired
);

   localparam int PW = $clog2(CYCLES_PER_100MS);
   localparam int TW = $clog2(TICKS_PER_SEC);
   localparam logic [PW-1:0] PRE_LAST = PW'(CYCLES_PER_100MS - 1);
   localparam logic [TW-1:0] TEN_LAST = TW'(TICKS_PER_SEC - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} stateT;

   stateT         state;
   stateT         stateNext;
   logic [PW-1:0] prescaler;
   logic [TW-1:0] tenths;
   logic          wrapPend;   // a prescaler wrap happened on the previous edge
   logic          secPend;    // that wrap also wrapped the tenths counter
   logic          preWrap;
   logic          tenWrap;
   logic [7:0]    secsNext;

   // Wraps are only counted in RUN. A Pause sampled on the wrap edge still
   // lets the wrap register, because the state is still RUN on that edge.
   assign preWrap  = (state == RUN) && (prescaler == PRE_LAST);
   assign tenWrap  = preWrap && (tenths == TEN_LAST);

   // The decrement lands together with OnesecTimeout, one edge after the wrap.
   // It saturates at zero.
   assign secsNext = (secPend && (SecsLeft != 8'd0)) ? (SecsLeft - 8'd1) : SecsLeft;

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (Start && !Pause && (SecsLeft != 8'd0)) stateNext = RUN;
         RUN:     if (Pause) stateNext = PAUSED;
         PAUSED:  if (Start && !Pause) stateNext = RUN;
         EXPIRED: stateNext = EXPIRED;
      endcase
      // Reaching zero overrides any Start/Pause transition on the same edge.
      if (secPend && (secsNext == 8'd0)) stateNext = EXPIRED;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         prescaler        <= '0;
         tenths           <= '0;
         wrapPend         <= 1'b0;
         secPend          <= 1'b0;
         SecsLeft         <= 8'd0;
         HundredmsTimeout <= 1'b0;
         OnesecTimeout    <= 1'b0;
         Running          <= 1'b0;
         Expired          <= 1'b0;
      end else if (Load) begin
         // Load discards any in-flight wrap so no stale strobe follows it.
         state            <= IDLE;
         prescaler        <= '0;
         tenths           <= '0;
         wrapPend         <= 1'b0;
         secPend          <= 1'b0;
         SecsLeft         <= LoadSecs;
         HundredmsTimeout <= 1'b0;
         OnesecTimeout    <= 1'b0;
         Running          <= 1'b0;
         Expired          <= 1'b0;
      end else begin
         if (state == RUN) begin
            prescaler <= preWrap ? '0 : prescaler + PW'(1);
            if (preWrap) tenths <= tenWrap ? '0 : tenths + TW'(1);
         end
         wrapPend         <= preWrap;
         secPend          <= tenWrap;
         HundredmsTimeout <= wrapPend;
         OnesecTimeout    <= secPend;
         SecsLeft         <= secsNext;
         state            <= stateNext;
         Running          <= (stateNext == RUN);
         Expired          <= (stateNext == EXPIRED);
      end
   end

endmodule

// File: tb/tb_timeout_gen.sv
// ---------------------------------------------------------------------------
// tb_timeout_gen
// Self-checking bench for timeout_gen with CYCLES_PER_100MS=4, TICKS_PER_SEC=5.
//
// The reference model counts run-edges since the last Load. A 100 ms wrap
// happens on every multiple of C run-edges. A one-second wrap happens on
// every multiple of C*T run-edges. Each wrap queues an expected strobe for
// the following edge. A monitor on the falling edge compares the strobes and
// the output levels.
// ---------------------------------------------------------------------------
module tb_timeout_gen;

   localparam int C = 4;
   localparam int T = 5;
   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_EXPIRED = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       Load = 1'b0;
   logic [7:0] LoadSecs = 8'd0;
   logic       Start = 1'b0;
   logic       Pause = 1'b0;
   logic       HundredmsTimeout;
   logic       OnesecTimeout;
   logic [7:0] SecsLeft;
   logic       Running;
   logic       Expired;

   timeout_gen #(.CYCLES_PER_100MS(C), .TICKS_PER_SEC(T)) dut (
      .clk              (clk),
      .rst              (rst),
      .Load             (Load),
      .LoadSecs         (LoadSecs),
      .Start            (Start),
      .Pause            (Pause),
      .HundredmsTimeout (HundredmsTimeout),
      .OnesecTimeout    (OnesecTimeout),
      .SecsLeft         (SecsLeft),
      .Running          (Running),
      .Expired          (Expired)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic       one;
      logic [7:0] secs;
   } expT;
   expT expQ[$];

   // Reference model state
   int mState = S_IDLE;
   int mSecs = 0;
   int mRunEdges = 0;
   bit mPend = 1'b0;
   bit mPendOne = 1'b0;
   int nState;
   bit wrapNow;
   bit oneNow;

   int hundredCnt = 0;
   int onesecCnt = 0;
   int firstOnesecCyc = -1;
   int sCyc = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            mState = S_IDLE; mSecs = 0; mRunEdges = 0; mPend = 0; mPendOne = 0;
            expQ.delete();
         end else if (Load) begin
            mState = S_IDLE; mSecs = int'(LoadSecs); mRunEdges = 0; mPend = 0; mPendOne = 0;
         end else begin
            nState = mState;
            case (mState)
               S_IDLE:   if (Start && !Pause && mSecs != 0) nState = S_RUN;
               S_RUN:    if (Pause) nState = S_PAUSED;
               S_PAUSED: if (Start && !Pause) nState = S_RUN;
               default:  nState = mState;
            endcase
            wrapNow = 0; oneNow = 0;
            if (mState == S_RUN) begin
               mRunEdges++;
               if (mRunEdges % C == 0) begin
                  wrapNow = 1;
                  oneNow  = (mRunEdges % (C * T) == 0);
               end
            end
            if (mPend) begin
               if (mPendOne && mSecs > 0) mSecs--;
               expQ.push_back('{one: mPendOne, secs: 8'(mSecs)});
               if (mPendOne && mSecs == 0) nState = S_EXPIRED;
            end
            mPend = wrapNow; mPendOne = oneNow; mState = nState;
         end
      end
   end

   // Monitor / scoreboard
   initial begin
      expT e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("running_level", int'(Running), int'(mState == S_RUN));
            check("expired_level", int'(Expired), int'(mState == S_EXPIRED));
            check("secs_left", int'(SecsLeft), mSecs);
            if (HundredmsTimeout) begin
               hundredCnt++;
               check("strobe_expected", int'(expQ.size() > 0), 1);
               if (expQ.size() > 0) begin
                  e = expQ.pop_front();
                  check("onesec_flag", int'(OnesecTimeout), int'(e.one));
                  check("strobe_secs", int'(SecsLeft), int'(e.secs));
                  $display("strobe cyc=%0d onesec=%0d secs=%0d", cyc, OnesecTimeout, SecsLeft);
               end
               if (OnesecTimeout) begin
                  onesecCnt++;
                  if (firstOnesecCyc < 0) firstOnesecCyc = cyc;
               end
            end else begin
               check("onesec_alone", int'(OnesecTimeout), 0);
            end
            check("missed_strobe", expQ.size(), 0);
            expQ.delete();
         end
      end
   end

   task automatic drive(input bit ld, input int secs, input bit st, input bit ps);
      @(negedge clk);
      Load = ld; LoadSecs = 8'(secs); Start = st; Pause = ps;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 0, 0, 0);
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "_100ms"}, int'(HundredmsTimeout), 0);
      check({tag, "_onesec"}, int'(OnesecTimeout), 0);
      check({tag, "_secs"}, int'(SecsLeft), 0);
      check({tag, "_running"}, int'(Running), 0);
      check({tag, "_expired"}, int'(Expired), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #2 rst = 1'b1;
      #1 checkAllZero("reset");
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // Start with SecsLeft==0 is ignored
      drive(0, 0, 1, 0);
      idle(5);
      check("start_zero_running", int'(Running), 0);

      // Basic countdown from 3
      drive(1, 3, 0, 0);
      drive(0, 0, 1, 0);
      sCyc = cyc; hundredCnt = 0; onesecCnt = 0; firstOnesecCyc = -1;
      idle(70);
      check("basic_onesec_count", onesecCnt, 3);
      check("basic_100ms_count", hundredCnt, 15);
      check("basic_first_onesec_cyc", firstOnesecCyc, sCyc + C * T + 2);
      check("basic_expired", int'(Expired), 1);
      check("basic_running", int'(Running), 0);
      check("basic_secs", int'(SecsLeft), 0);

      // Start in EXPIRED does nothing; Load leaves EXPIRED
      drive(0, 0, 1, 0);
      idle(2);
      check("exp_start_expired", int'(Expired), 1);
      check("exp_start_running", int'(Running), 0);
      drive(1, 2, 0, 0);
      drive(0, 0, 0, 0);
      check("exp_load_expired", int'(Expired), 0);
      check("exp_load_secs", int'(SecsLeft), 2);
      check("exp_load_running", int'(Running), 0);

      // Pause held 17 cycles mid-second, then resume
      drive(1, 3, 0, 0);
      drive(0, 0, 1, 0);
      sCyc = cyc; onesecCnt = 0; firstOnesecCyc = -1;
      idle(7);
      repeat (17) drive(0, 0, 0, 1);
      drive(0, 0, 1, 0);
      idle(80);
      check("pause_first_onesec_cyc", firstOnesecCyc, sCyc + C * T + 2 + 17);
      check("pause_onesec_count", onesecCnt, 3);
      check("pause_expired", int'(Expired), 1);

      // Load + Start + Pause together: Load wins
      drive(1, 5, 0, 0);
      drive(0, 0, 1, 0);
      idle(10);
      drive(1, 7, 1, 1);
      drive(0, 0, 0, 0);
      check("prio_secs", int'(SecsLeft), 7);
      check("prio_running", int'(Running), 0);
      check("prio_expired", int'(Expired), 0);
      hundredCnt = 0;
      idle(30);
      check("prio_no_strobes", hundredCnt, 0);

      // Asynchronous reset between edges while running
      drive(1, 5, 0, 0);
      drive(0, 0, 1, 0);
      idle(30);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 checkAllZero("async_rst");
      #1 rst = 1'b0;
      hundredCnt = 0;
      idle(30);
      drive(0, 0, 1, 0);
      idle(30);
      check("post_rst_no_strobes", hundredCnt, 0);
      check("post_rst_running", int'(Running), 0);

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         drive($urandom_range(0, 39) == 0, int'($urandom_range(0, 3)),
               $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0);
      end
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/timeout_gen.md
TIMEOUT_GEN -- requirements
Module: timeout_gen

Interface
REQ-001 Parameter CYCLES_PER_100MS, default 5000000, SHALL be the clk cycles per 100 ms tick (50 MHz clk); legal range >= 2.
REQ-002 Parameter TICKS_PER_SEC, default 10, SHALL be the 100 ms ticks per one-second tick; legal range >= 2.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 Load  input  1  SHALL, when high, load LoadSecs as the countdown value.
REQ-006 LoadSecs  input  8  SHALL be the countdown start value in seconds, sampled only when Load=1.
REQ-007 Start  input  1  SHALL start or resume the countdown.
REQ-008 Pause  input  1  SHALL freeze the countdown.
REQ-009 HundredmsTimeout  output  1  SHALL be a one-cycle strobe every 100 ms while running.
REQ-010 OnesecTimeout  output  1  SHALL be a one-cycle strobe every TICKS_PER_SEC HundredmsTimeout strobes.
REQ-011 SecsLeft  output  8  SHALL be the seconds remaining.
REQ-012 Running  output  1  SHALL be high only in state RUN.
REQ-013 Expired  output  1  SHALL be a level, high only in state EXPIRED.

Function
REQ-014 States SHALL be IDLE, RUN, PAUSED and EXPIRED, held in a registered state variable.
REQ-015 Prescaler width SHALL be $clog2(CYCLES_PER_100MS); it counts 0..CYCLES_PER_100MS-1 and wraps to 0.
REQ-016 Tenths counter width SHALL be $clog2(TICKS_PER_SEC); it counts 0..TICKS_PER_SEC-1 and wraps to 0.
REQ-017 Load=1 in any state SHALL set SecsLeft=LoadSecs, clear the prescaler and tenths counter, and enter IDLE; Load SHALL win over Start and Pause in the same cycle.
REQ-018 IDLE with Start=1, Pause=0 and SecsLeft!=0 SHALL enter RUN; Start with SecsLeft==0 SHALL be ignored (stay IDLE).
REQ-019 RUN with Pause=1 SHALL enter PAUSED; Pause SHALL win over a simultaneous Start.
REQ-020 PAUSED with Start=1, Pause=0 SHALL return to RUN with the prescaler and tenths counter unchanged (resume, not restart).
REQ-021 The prescaler SHALL increment only in RUN and hold in IDLE, PAUSED and EXPIRED.
REQ-022 HundredmsTimeout SHALL be registered and assert for exactly one cycle on the cycle after the prescaler wraps.
REQ-023 The first HundredmsTimeout after entering RUN from IDLE SHALL assert CYCLES_PER_100MS+1 cycles after the edge that sampled Start.
REQ-024 The tenths counter SHALL advance on each prescaler wrap.
REQ-025 On a tenths-counter wrap, the block SHALL:
- assert OnesecTimeout for one cycle, coincident with HundredmsTimeout;
- decrement SecsLeft by 1 in that same cycle.
REQ-026 If SecsLeft becomes 0 by that decrement, the state SHALL become EXPIRED in the same cycle.
REQ-027 SecsLeft SHALL never wrap below 0.
REQ-028 EXPIRED SHALL hold until Load or rst; Start and Pause SHALL be ignored in EXPIRED.
REQ-029 A Pause arriving in the same cycle as a prescaler wrap SHALL still let that wrap's strobes and decrement take effect; counting SHALL freeze from the next cycle.
REQ-030 Strobes SHALL never assert outside RUN, apart from the registered strobe issued for a wrap that occurred in RUN.

Reset
REQ-031 rst=1 SHALL immediately, without clk, force:
- state IDLE;
- prescaler=0, tenths=0, SecsLeft=0;
- HundredmsTimeout=0, OnesecTimeout=0, Running=0, Expired=0.
REQ-032 rst asserted mid-countdown SHALL discard all progress; after release, the block SHALL behave as freshly reset and require Load then Start.

Verification (bench parameters CYCLES_PER_100MS=4, TICKS_PER_SEC=5)
REQ-033 Basic countdown: Load with LoadSecs=3, then Start.
- HundredmsTimeout every 4 cycles;
- OnesecTimeout every 20 cycles;
- SecsLeft steps 3->2->1->0;
- Expired=1 and Running=0 at 60 cycles after the first strobe window.
REQ-034 Pause/resume: Pause held 17 cycles mid-second, then Start.
- No strobes while paused;
- the next OnesecTimeout is delayed by exactly 17 cycles relative to the unpaused run.
REQ-035 Priority: Load=1, Start=1 and Pause=1 in the same cycle with LoadSecs=7 -> state IDLE, SecsLeft=7, no strobes.
REQ-036 Zero and expiry:
- Load 0 then Start -> stays IDLE, Running=0;
- Start in EXPIRED -> no change;
- Load 2 in EXPIRED -> IDLE, Expired=0, SecsLeft=2.
REQ-037 Asynchronous reset: rst pulsed between clk edges during RUN with SecsLeft=5 -> all outputs 0 before the next edge; no strobes after release until Load and Start.
